// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use an iterative shift-add multiplier. DIV/DIVU use a restoring
// shift-subtract divider. Each runs one iteration per clock.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start, op         request an operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   operand0/1        rs / rt, sampled on the accept edge
//   mthi, mtlo        write wr_data into HI / LO (only while idle and not starting)
//   wr_data           data for MTHI/MTLO
//   hi, lo            HI/LO registers (product or remainder/quotient)
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle pulse; hi/lo already show the new result
//   div_by_zero       last divide had a zero divisor; cleared on the next accept
module mul_div_unit #(
  parameter int Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [Data_Width-1:0] operand0,
  input  logic [Data_Width-1:0] operand1,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [Data_Width-1:0] wr_data,
  output logic [Data_Width-1:0] hi,
  output logic [Data_Width-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int W     = Data_Width;
  localparam int CNT_W = $clog2(Data_Width);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dz_r;
  logic [W-1:0]     hi_reg, lo_reg;

  // Iteration datapath: acc_hi/acc_lo hold the product accumulator while
  // multiplying, or remainder/quotient-with-dividend while dividing.
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [W-1:0]     b_mag;
  logic [W-1:0]     acc_hi, acc_lo;

  logic             accept;
  logic             dz_accept;
  logic             write_fix;
  logic [W:0]       mul_sum;
  logic [W:0]       div_trial;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     hi_fix, lo_fix;

  // Two's-complement magnitude when the operand is treated as signed.
  // The most-negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v, input logic is_signed);
    if (is_signed && v < 0) return ~v + 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] negate_w(input logic [W-1:0] v, input logic en);
    if (en) return ~v + 1'b1;
    return v;
  endfunction

  function automatic logic [2*W-1:0] negate_2w(input logic [2*W-1:0] v, input logic en);
    if (en) return ~v + 1'b1;
    return v;
  endfunction

  assign accept    = start && (state == IDLE);
  assign dz_accept = accept && op[1] && (operand1 == '0);
  assign write_fix = (state == FIX) && !dz_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = dz_accept ? FIX : RUN;
      RUN:  if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN: busy = 1'b1;
      FIX: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-iteration arithmetic
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag : {W{1'b0}})};
    div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, b_mag};
  end

  // Sign correction: the full double-width product is negated, while
  // quotient and remainder are corrected independently.
  always_comb begin
    prod_fix = negate_2w({acc_hi, acc_lo}, neg_q_r);
    hi_fix   = prod_fix[2*W-1:W];
    lo_fix   = prod_fix[W-1:0];
    if (is_div_r) begin
      lo_fix = negate_w(acc_lo, neg_q_r);
      hi_fix = negate_w(acc_hi, neg_r_r);
    end
  end

  // ---- accept / iterate stage ----
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_r <= op[1];
      neg_q_r  <= op[0] & (operand0[W-1] ^ operand1[W-1]);
      neg_r_r  <= op[0] & operand0[W-1];
      b_mag    <= magnitude(operand1, op[0]);
      acc_lo   <= magnitude(operand0, op[0]);
      acc_hi   <= '0;
    end else if (state == RUN) begin
      if (is_div_r) begin
        // A non-negative trial difference means the divisor fits: keep it.
        if (!div_trial[W]) begin
          acc_hi <= div_trial[W-1:0];
          acc_lo <= {acc_lo[W-2:0], 1'b1};
        end else begin
          acc_hi <= {acc_hi[W-2:0], acc_lo[W-1]};
          acc_lo <= {acc_lo[W-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
      end
    end
  end

  // ---- architectural state / control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      dz_r   <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (accept)             cnt <= '0;
      else if (state == RUN)  cnt <= cnt + 1'b1;

      if (accept) dz_r <= dz_accept;

      if (write_fix) begin
        hi_reg <= hi_fix;
        lo_reg <= lo_fix;
      end else if (state == IDLE && !start) begin
        if (mthi) hi_reg <= wr_data;
        if (mtlo) lo_reg <= wr_data;
      end
    end
  end

  // During FIX the corrected result is already visible so it lines up with done.
  assign hi          = write_fix ? hi_fix : hi_reg;
  assign lo          = write_fix ? lo_fix : lo_reg;
  assign div_by_zero = dz_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit: stimulus pushes the expected HI/LO/flag
// for every accepted operation; a monitor pops and compares on each done.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand0 = '0;
  logic [W-1:0] operand1 = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_by_zero;

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;

  mul_div_unit #(.Data_Width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand0(operand0), .operand1(operand1),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        chk("result_hi", hi, mon_e.h);
        chk("result_lo", lo, mon_e.l);
        chk("result_dz", div_by_zero, mon_e.dz);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input int elat, input logic with_mtlo, input logic [W-1:0] wd);
    int w;
    int lat;
    int bc;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    start = 1'b1; op = o; operand0 = a; operand1 = b;
    mtlo = with_mtlo; wr_data = wd;
    sb.push_back('{eh, el, edz});
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    chk("dz_on_accept", div_by_zero, edz);
    lat = 1;
    bc  = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bc++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("busy_cycles", bc, elat);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_ctl", {busy, done, div_by_zero}, 3'b000);

    // Multiply
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W+1, 1'b0, 0);
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, W+1, 1'b0, 0);
    run_op(2'b01, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, W+1, 1'b0, 0);
    run_op(2'b01, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, W+1, 1'b0, 0);
    run_op(2'b01, 32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0, W+1, 1'b0, 0);

    // Divide
    run_op(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W+1, 1'b0, 0);
    run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, W+1, 1'b0, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, W+1, 1'b0, 0);
    run_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, W+1, 1'b0, 0);

    // MTHI / MTLO, then divide by zero leaves them untouched
    mthi = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi", hi, 32'h1234);
    mtlo = 1'b1; wr_data = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo", lo, 32'h5678);
    run_op(2'b10, 32'd5, 32'd0, 32'h1234, 32'h5678, 1'b1, 1, 1'b0, 0);
    chk("dz_held", div_by_zero, 1'b1);
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, W+1, 1'b0, 0);

    // Both writes together
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hA5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_hi", hi, 32'hA5A5);
    chk("mthi_mtlo_lo", lo, 32'hA5A5);

    // Start and MTHI while busy are ignored
    start = 1'b1; op = 2'b00; operand0 = 32'd6; operand1 = 32'd7;
    sb.push_back('{32'd0, 32'd42, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; operand0 = 32'd9; operand1 = 32'd0;
    mthi = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("hi_during_run", hi, 32'hA5A5);
    chk("dz_not_set_by_ignored", div_by_zero, 1'b0);
    chk("busy_during_run", busy, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    // Start during the done cycle is dropped too
    start = 1'b1; op = 2'b00; operand0 = 32'd1; operand1 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", busy, 1'b0);

    // Start with MTLO in idle: the write is dropped, divide-by-zero keeps LO
    run_op(2'b10, 32'd9, 32'd0, 32'd0, 32'd42, 1'b1, 1, 1'b1, 32'hBEEF);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand0 = 32'hFFFFFFFD; operand1 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_ctl", {busy, done, div_by_zero}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, W+1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle multiply/divide unit that extends the single-cycle ALU with MIPS MULT/MULTU/DIV/DIVU and the architectural HI/LO registers. It runs an iterative shift-add multiplier and a restoring divider, parametrised in data width. It sits beside the ALU in the execute stage; the controller stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

Parameters:
- Data_Width, 32: operand, HI and LO width. Must be even and >= 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only when `busy`=0.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled on accept.
- operand0  input  Data_Width  multiplicand or dividend (rs). Sampled on accept.
- operand1  input  Data_Width  multiplier or divisor (rt). Sampled on accept.
- mthi  input  1  write `wr_data` into HI.
- mtlo  input  1  write `wr_data` into LO.
- wr_data  input  Data_Width  data for MTHI/MTLO.
- hi  output  Data_Width  HI register: product upper half, or remainder.
- lo  output  Data_Width  LO register: product lower half, or quotient.
- busy  output  1  high from the cycle after accept until `done`, inclusive.
- done  output  1  one-cycle pulse; HI/LO hold the new result in that same cycle.
- div_by_zero  output  1  high when the last DIV/DIVU had divisor 0; cleared on the next accept.

Behaviour:
Reset (asynchronous):
- `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, FSM=IDLE.
- Reset asserted mid-operation aborts it: no `done`, HI/LO forced to 0.

FSM states: IDLE, RUN, FIX.
- IDLE -> RUN when `start`=1 (accept edge). The accept edge:
  - latches `op`;
  - latches the magnitudes of the operands (two's-complement absolute value when op is MULT or DIV, raw otherwise);
  - latches the result signs;
  - clears the iteration counter and `div_by_zero`.
- RUN: one iteration per cycle, exactly Data_Width cycles, then RUN -> FIX.
  - Multiply: shift-add over a 2*Data_Width accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX: one cycle. Applies sign correction, writes HI/LO, asserts `done`=1, then FIX -> IDLE.
- Latency: `done` is high in cycle Data_Width+1 after the accept edge (33 for Data_Width=32). `busy` is 1 for Data_Width+1 cycles.

Divide-by-zero:
- On accept of DIV/DIVU with `operand1`=0, go directly to FIX. `done` is high 1 cycle after accept.
- `div_by_zero`=1, HI/LO unchanged.

Signed result rules:
- Product sign = sign0 XOR sign1; the full 2*Data_Width negation is applied in FIX.
- Quotient sign = sign0 XOR sign1; remainder takes the sign of the dividend.
- Most-negative / -1: LO = most-negative (wraps), HI = 0, no flag.

Priority and simultaneous events:
- `start` while `busy`=1 is ignored; nothing is queued.
- `mthi`/`mtlo` while `busy`=1 are ignored.
- In IDLE, `start`=1 takes priority over `mthi`/`mtlo` in the same cycle; the writes are dropped.
- `mthi`=`mtlo`=1 together in IDLE writes both HI and LO.
- `start` in the cycle `done` is high is ignored (`busy`=1). A new start is accepted the following cycle.
- No overflow flag; results are exact 2*Data_Width for multiply.

Test Plan:
1. Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> `done` at cycle 33, HI=0xFFFFFFFE, LO=0x00000001, `busy` high for 33 cycles.
2. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0; then MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
4. MTHI 0x1234, MTLO 0x5678, then DIVU 5 / 0 -> `done` 1 cycle after accept, `div_by_zero`=1, HI=0x1234, LO=0x5678; next accepted start clears `div_by_zero`.
5. Start during RUN, plus `mthi` during RUN, plus `start` and `mtlo` together in IDLE -> busy op unaffected, HI unchanged by the ignored write, LO not written, second op runs normally.
6. Assert `rst` at cycle 10 of a MULT -> outputs 0 immediately (asynchronous), no `done` pulse; a fresh MULTU 3 x 4 after release gives LO=12, HI=0.
